// File: rtl/pakage_fifo.sv
// pakage_fifo: single-clock word FIFO with a registered output stage.
// Storage is a DEPTH-word RAM plus one output register; the total number of
// words held (level) never exceeds DEPTH.
// Optional build macro PAKAGE_FIFO_BURST_EN adds the registered burst_avail
// flag (level >= BURST_LEN).
module pakage_fifo #(
    parameter int DATA_W    = 512,
    parameter int DEPTH     = 256,
    parameter int BURST_LEN = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AW:0]       level
`ifdef PAKAGE_FIFO_BURST_EN
    ,
    output logic              burst_avail
`endif
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pakage_fifo: DEPTH must be a power of two >= 4");
    end
    if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_burst
        $error("pakage_fifo: BURST_LEN must be in 1..DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              wr_en;
    logic              rd_en;
    logic              ram_empty;
    logic              bypass;
    logic              ram_wr;
    logic              load;
    logic [AW:0]       level_nxt;

    // Transfer decode, output-register refill and next level.
    // The RAM never holds DEPTH words (the output register takes one slot
    // whenever the RAM is non-empty), so wptr == rptr means RAM empty.
    // A write that meets a consumed output register with an empty RAM goes
    // straight into the output register so out_valid never drops.
    always_comb begin
        wr_en     = in_valid && in_ready;
        rd_en     = out_valid && out_ready;
        ram_empty = (wptr == rptr);
        bypass    = wr_en && rd_en && ram_empty;
        ram_wr    = wr_en && !bypass;
        load      = !ram_empty && (!out_valid || out_ready);
        level_nxt = level;
        if (wr_en && !rd_en) begin
            level_nxt = level + (AW + 1)'(1);
        end else if (!wr_en && rd_en) begin
            level_nxt = level - (AW + 1)'(1);
        end
    end

    // RAM write port; contents are intentionally left untouched by reset.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[wptr] <= in_data;
        end
    end

    // Pointers, level, ready flag and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            level    <= level_nxt;
            in_ready <= (level_nxt != FULL_LVL);
            if (ram_wr) begin
                wptr <= wptr + AW'(1);
            end
            if (load) begin
                out_data  <= mem[rptr];
                out_valid <= 1'b1;
                rptr      <= rptr + AW'(1);
            end else if (bypass) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else if (rd_en) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PAKAGE_FIFO_BURST_EN
    // Registered burst indicator tracking the post-edge level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_avail <= 1'b0;
        end else begin
            burst_avail <= (level_nxt >= (AW + 1)'(BURST_LEN));
        end
    end
`endif

endmodule

// File: tb/tb_pakage_fifo.sv
// tb_pakage_fifo: randomized and directed stimulus for pakage_fifo, checked
// against a queue-based reference model of the FIFO's observable behaviour.
module tb_pakage_fifo;

    localparam int DATA_W    = 64;
    localparam int DEPTH     = 256;
    localparam int BURST_LEN = 16;
    localparam int AW        = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [AW:0]       level;
`ifdef PAKAGE_FIFO_BURST_EN
    logic              burst_avail;
`endif

    pakage_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .level    (level)
`ifdef PAKAGE_FIFO_BURST_EN
        ,
        .burst_avail(burst_avail)
`endif
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model: every held word in acceptance order, plus the
    // expected visibility of the head word and the ready flag.
    logic [DATA_W-1:0] q[$];
    logic              m_valid = 1'b0;
    logic              m_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one rising edge to the model using the inputs present at the edge.
    // The head becomes visible once it has been held across a full edge, or
    // immediately when a word arrives as the sole held word leaves.
    task automatic model_edge();
        int  old_n;
        bit  push;
        bit  pop;
        if (!rst_n) begin
            q.delete();
            m_valid = 1'b0;
            m_ready = 1'b0;
            return;
        end
        old_n = q.size();
        push  = in_valid && m_ready;
        pop   = out_ready && m_valid;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(in_data);
        m_valid = ((old_n - int'(pop)) > 0) || (push && pop && old_n == 1);
        m_ready = (q.size() != DEPTH);
    endtask

    task automatic compare();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("level", 64'(level), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        if (m_valid) chk("out_data", out_data, q[0]);
`ifdef PAKAGE_FIFO_BURST_EN
        chk("burst_avail", 64'(burst_avail), 64'(rst_n && q.size() >= BURST_LEN));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        q.delete();
        m_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        compare();
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic rand_phase(input int unsigned cycles, input int unsigned p_in, input int unsigned p_out);
        for (int unsigned i = 0; i < cycles; i++) begin
            in_valid  = ($urandom_range(99) < p_in);
            in_data   = {32'($urandom()), 32'($urandom())};
            out_ready = ($urandom_range(99) < p_out);
            step();
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int unsigned i = 0; i < DEPTH + 4 && q.size() != 0; i++) step();
        chk("drain_empty", 64'(level), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        do_reset();

        // Single word, consumer stalled: appears two edges later and holds.
        in_valid = 1'b1;
        in_data  = {DATA_W/8{8'hA5}};
        step();
        in_valid = 1'b0;
        for (int unsigned i = 0; i < 4; i++) step();
        chk("a5_data", out_data, {DATA_W/8{8'hA5}});

        // Fill to capacity with incrementing words, then offer extra words.
        do_reset();
        for (int unsigned i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            step();
        end
        chk("full_level", 64'(level), 64'(DEPTH));
        chk("full_ready", 64'(in_ready), 64'd0);
        in_data = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int unsigned i = 0; i < 3; i++) step();
        chk("full_ignored", 64'(level), 64'(DEPTH));

        // One read from full.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("after_read_level", 64'(level), 64'(DEPTH - 1));
        chk("after_read_ready", 64'(in_ready), 64'd1);
        chk("after_read_head", out_data, 64'd1);
        drain();

        // Continuous streaming in and out for 1000 words.
        for (int unsigned i = 0; i < 1000; i++) begin
            in_valid  = 1'b1;
            in_data   = 64'(i + 32'h1000);
            out_ready = 1'b1;
            step();
        end
        drain();

        // Randomised traffic at several fill/drain balances.
        rand_phase(600, 50, 50);
        rand_phase(600, 90, 30);
        rand_phase(600, 95, 10);
        rand_phase(600, 20, 80);
        rand_phase(600, 100, 100);

        // Reset mid-stream at level 100.
        drain();
        for (int unsigned i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h0BAD_0000_0000_0000 | 64'(i);
            step();
        end
        chk("pre_reset_level", 64'(level), 64'd100);
        rst_n = 1'b0;
        q.delete();
        m_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_level", 64'(level), 64'd0);
        in_valid = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        rand_phase(400, 60, 60);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
